// File: rtl/seq_alu.sv
// seq_alu: registered ALU with flags, start/done handshake and an iterative shift-add multiplier
module seq_alu #(
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           operation,
  input  logic [word_size-1:0] operandA,
  input  logic [word_size-1:0] operandB,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] result,
  output logic                 zero,
  output logic                 negative,
  output logic                 carry,
  output logic                 overflow
);
  localparam int shamt_w = $clog2(word_size);
  localparam int msb = word_size - 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [2*word_size-1:0] acc, mcand, acc_nxt;
  logic [word_size-1:0] mplier, res;
  logic [shamt_w-1:0] cnt, sh;
  logic [word_size:0] sum, diff;
  logic c, v;
  assign sh = operandB[shamt_w-1:0];
  assign sum = {1'b0, operandA} + {1'b0, operandB};
  assign diff = {1'b0, operandA} - {1'b0, operandB};
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (operation)
      4'd0: begin
        res = sum[msb:0];
        c = sum[word_size];
        v = (operandA[msb] == operandB[msb]) && (sum[msb] != operandA[msb]);
      end
      4'd1: begin
        res = diff[msb:0];
        c = diff[word_size];
        v = (operandA[msb] != operandB[msb]) && (diff[msb] != operandA[msb]);
      end
      4'd2: res = operandA & operandB;
      4'd3: res = operandA | operandB;
      4'd4: res = operandA ^ operandB;
      4'd5: res = operandA << sh;
      4'd6: res = operandA >> sh;
      4'd7: res = $signed(operandA) >>> sh;
      4'd8: res = {{msb{1'b0}}, $signed(operandA) < $signed(operandB)};
      4'd9: res = {{msb{1'b0}}, operandA < operandB};
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      zero <= 1'b1;
      negative <= 1'b0;
      carry <= 1'b0;
      overflow <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && operation == 4'b1010) begin
          acc <= '0;
          mcand <= {{word_size{1'b0}}, operandA};
          mplier <= operandB;
          cnt <= '0;
          busy <= 1'b1;
          state <= MUL;
        end else if (start) begin
          result <= res;
          zero <= res == '0;
          negative <= res[msb];
          carry <= c;
          overflow <= v;
          done <= 1'b1;
        end
      end else begin
        acc <= acc_nxt;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        // last of word_size iterations: the sum including this step is the product
        if (&cnt) begin
          result <= acc_nxt[msb:0];
          zero <= acc_nxt[msb:0] == '0;
          negative <= acc_nxt[msb];
          carry <= |acc_nxt[2*word_size-1:word_size];
          overflow <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] operation = 0;
  logic [15:0] operandA = 0, operandB = 0;
  logic busy, done, zero, negative, carry, overflow;
  logic [15:0] result;
  int checks = 0, errors = 0;

  seq_alu #(.word_size(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .operandA(operandA), .operandB(operandB), .busy(busy), .done(done),
    .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns {overflow, carry, result}
  function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, t;
    longint p;
    logic [15:0] r;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    r = 0; c = 0; v = 0;
    case (op)
      0: begin t = int'(a) + int'(b); r = t[15:0]; c = t > 65535; t = sa + sb; v = t > 32767 || t < -32768; end
      1: begin t = sa - sb; r = t[15:0]; c = a < b; v = t > 32767 || t < -32768; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << b[3:0];
      6: r = a >> b[3:0];
      7: begin t = sa >>> b[3:0]; r = t[15:0]; end
      8: r = (sa < sb) ? 16'd1 : 16'd0;
      9: r = (a < b) ? 16'd1 : 16'd0;
      10: begin p = longint'(a) * longint'(b); r = p[15:0]; c = p > 65535; end
      default: ;
    endcase
    return {v, c, r};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1; operation = op; operandA = a; operandB = b;
    @(posedge clk);
    #1;
  endtask

  // called #1 after the accepting edge; n0 = edges already elapsed since that edge
  task automatic wait_chk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int n0);
    logic [17:0] m;
    int n;
    n = n0;
    m = model(op, a, b);
    if (op == 10) chk($sformatf("busy op%0d", op), 32'(busy), 1);
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("latency op%0d", op), n, (op == 10) ? 16 : 0);
    chk($sformatf("result op%0d %h,%h", op, a, b), 32'(result), 32'(m[15:0]));
    chk($sformatf("zero op%0d", op), 32'(zero), 32'(m[15:0] == 0));
    chk($sformatf("negative op%0d", op), 32'(negative), 32'(m[15]));
    chk($sformatf("carry op%0d %h,%h", op, a, b), 32'(carry), 32'(m[16]));
    chk($sformatf("overflow op%0d %h,%h", op, a, b), 32'(overflow), 32'(m[17]));
    chk($sformatf("busy after op%0d", op), 32'(busy), 0);
  endtask

  task automatic exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    issue(op, a, b);
    start = 0;
    wait_chk(op, a, b, 0);
  endtask

  initial begin
    int pulses;
    logic [3:0] op;
    logic [15:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", 32'(result), 0);
    chk("reset zero", 32'(zero), 1);
    chk("reset flags", {29'd0, negative, carry, overflow}, 0);
    rst_n = 1;

    // reset aborts a multiply in flight
    issue(4'd10, 16'h0003, 16'h0005);
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 0;
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; pulses += int'(done); end
    rst_n = 1;
    chk("abort busy", 32'(busy), 0);
    chk("abort result", 32'(result), 0);
    chk("abort zero", 32'(zero), 1);
    repeat (20) begin @(posedge clk); #1; pulses += int'(done); end
    chk("abort no done", pulses, 0);

    exec(4'd0, 16'hFFFF, 16'h0001);
    exec(4'd0, 16'h7FFF, 16'h0001);
    exec(4'd1, 16'h0003, 16'h0005);
    exec(4'd1, 16'h8000, 16'h0001);
    exec(4'd7, 16'h8000, 16'h0013);
    exec(4'd6, 16'h8000, 16'h0013);
    exec(4'd5, 16'h8001, 16'h00F4);
    exec(4'd8, 16'hFFFF, 16'h0001);
    exec(4'd9, 16'hFFFF, 16'h0001);
    exec(4'd10, 16'h0003, 16'h0005);
    exec(4'd10, 16'h0100, 16'h0100);
    exec(4'd15, 16'h1234, 16'hABCD);

    // start while busy must be ignored
    issue(4'd10, 16'h0003, 16'h0005);
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    issue(4'd0, 16'h1111, 16'h2222);
    start = 0;
    wait_chk(4'd10, 16'h0003, 16'h0005, 4);
    @(posedge clk);
    #1;
    chk("done one pulse", 32'(done), 0);

    // back-to-back single-cycle ops, then mul issued while done is high
    for (int i = 0; i < 3; i++) begin
      op = 4'(2 + i);
      issue(op, 16'hF0F0, 16'h0FF0);
      chk($sformatf("b2b done %0d", i), 32'(done), 1);
      chk($sformatf("b2b result %0d", i), 32'(result), 32'(model(op, 16'hF0F0, 16'h0FF0) & 18'hFFFF));
    end
    issue(4'd10, 16'h1234, 16'h0021);
    start = 0;
    wait_chk(4'd10, 16'h1234, 16'h0021, 0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 7 == 0) a = 16'h8000;
      if (i % 11 == 0) b = 16'hFFFF;
      exec(op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
